// File: rtl/filter_stream_ctrl_pkg.sv
// Shared types and widths for the filter-stream controller.
// Optional FILTER_STREAM_PERF_EN build adds beat/stall counters to the top.
package filter_stream_ctrl_pkg;

   localparam int NUM_LAYERS = 4;
   localparam int MAX_K      = 64;
   localparam int WT_AW      = 12;
   localparam int WT_DW      = 32;
   localparam int CNT_W      = 10;

   localparam int K_W        = $clog2(MAX_K);
   localparam int LAYER_W    = $clog2(NUM_LAYERS);
   localparam int SKID_DW    = WT_DW + 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CALC,
      ST_STREAM,
      ST_DRAIN,
      ST_DONE
   } fs_state_t;

   typedef struct packed {
      logic [WT_AW-1:0] base;
      logic [CNT_W-1:0] words;
   } layer_cfg_t;

   // First word of group k; the SRAM address space wraps.
   function automatic logic [WT_AW-1:0] group_start(input layer_cfg_t cfg,
                                                    input logic [K_W-1:0] k);
      return cfg.base + WT_AW'(k) * WT_AW'(cfg.words);
   endfunction

endpackage

// File: rtl/filter_stream_skid.sv
// Two-entry FIFO between the SRAM read port and the weight stream.
// Occupancy feeds the read-issue throttle, so writes never find it full.
module filter_stream_skid
   import filter_stream_ctrl_pkg::*;
#(
   parameter int DW = SKID_DW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [DW-1:0] wr_data,
   input  logic          rd_en,
   output logic          head_valid,
   output logic [DW-1:0] head_data,
   output logic [1:0]    occupancy
);

   logic [DW-1:0] mem_reg [2];
   logic          wr_ptr_reg;
   logic          rd_ptr_reg;
   logic [1:0]    count_reg;
   logic          pop;

   assign head_valid = (count_reg != 2'd0);
   assign head_data  = mem_reg[rd_ptr_reg];
   assign occupancy  = count_reg;
   assign pop        = rd_en && head_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= 1'b0;
         rd_ptr_reg <= 1'b0;
         count_reg  <= 2'd0;
      end else begin
         if (wr_en) begin
            mem_reg[wr_ptr_reg] <= wr_data;
            wr_ptr_reg          <= ~wr_ptr_reg;
         end
         if (pop) begin
            rd_ptr_reg <= ~rd_ptr_reg;
         end
         count_reg <= count_reg + {1'b0, wr_en} - {1'b0, pop};
      end
   end

endmodule

// File: rtl/filter_stream_ctrl.sv
// Streams one k-group of compressed weights from SRAM to the PE weight buffer.
// Define FILTER_STREAM_PERF_EN to add perf_words / perf_stall counters.
module filter_stream_ctrl
   import filter_stream_ctrl_pkg::*;
(
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        req_valid,
   input  logic [K_W-1:0]              req_k,
   input  logic [LAYER_W-1:0]          req_layer,
   input  logic [NUM_LAYERS*WT_AW-1:0] cfg_base_addr,
   input  logic [NUM_LAYERS*CNT_W-1:0] cfg_words,
   output logic                        mem_rd_en,
   output logic [WT_AW-1:0]            mem_rd_addr,
   input  logic [WT_DW-1:0]            mem_rd_data,
   output logic                        wt_valid,
   output logic [WT_DW-1:0]            wt_data,
   output logic                        wt_last,
   input  logic                        wt_ready,
   output logic                        stream_filter_finish
`ifdef FILTER_STREAM_PERF_EN
   ,
   output logic [31:0]                 perf_words,
   output logic [31:0]                 perf_stall
`endif
);

   localparam logic [LAYER_W:0] LAYER_LIMIT = (LAYER_W+1)'(NUM_LAYERS);

   fs_state_t          state_reg;
   logic [K_W-1:0]     k_reg;
   logic [LAYER_W-1:0] layer_reg;
   logic [WT_AW-1:0]   addr_reg;
   logic [CNT_W-1:0]   remaining_reg;
   logic               inflight_reg;
   logic               inflight_last_reg;
   logic               finish_reg;

   layer_cfg_t         cfg_arr [NUM_LAYERS];
   layer_cfg_t         cfg_sel;
   logic               layer_ok;

   logic               skid_valid;
   logic [SKID_DW-1:0] skid_head;
   logic [1:0]         skid_occ;
   logic               pop;
   logic [2:0]         credit;
   logic               rd_issue;
   logic               drain_empty;

   generate
      for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_cfg
         assign cfg_arr[gi] = {cfg_base_addr[gi*WT_AW +: WT_AW], cfg_words[gi*CNT_W +: CNT_W]};
      end
   endgenerate

   assign layer_ok = ({1'b0, layer_reg} < LAYER_LIMIT);
   assign cfg_sel  = layer_ok ? cfg_arr[layer_reg] : '0;

   // The read strobe is combinational so a beat leaving the skid this cycle
   // frees its slot immediately; that is what sustains one word per cycle.
   assign pop         = skid_valid && wt_ready;
   assign credit      = {1'b0, skid_occ} - {2'b0, pop} + {2'b0, inflight_reg};
   assign rd_issue    = (state_reg == ST_STREAM) && (remaining_reg != '0) && (credit < 3'd2);
   assign drain_empty = !inflight_reg && (skid_occ == {1'b0, pop});

   assign mem_rd_en            = rd_issue;
   assign mem_rd_addr          = rd_issue ? addr_reg : '0;
   assign wt_valid             = skid_valid;
   assign wt_data              = skid_valid ? skid_head[WT_DW-1:0] : '0;
   assign wt_last              = skid_valid && skid_head[WT_DW];
   assign stream_filter_finish = finish_reg;

   filter_stream_skid #(.DW(SKID_DW)) u_skid (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (inflight_reg),
      .wr_data    ({inflight_last_reg, mem_rd_data}),
      .rd_en      (wt_ready),
      .head_valid (skid_valid),
      .head_data  (skid_head),
      .occupancy  (skid_occ)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg         <= ST_IDLE;
         k_reg             <= '0;
         layer_reg         <= '0;
         addr_reg          <= '0;
         remaining_reg     <= '0;
         inflight_reg      <= 1'b0;
         inflight_last_reg <= 1'b0;
         finish_reg        <= 1'b0;
      end else begin
         inflight_reg      <= rd_issue;
         inflight_last_reg <= rd_issue && (remaining_reg == CNT_W'(1));
         case (state_reg)
            ST_IDLE: begin
               finish_reg <= 1'b0;
               if (req_valid) begin
                  k_reg     <= req_k;
                  layer_reg <= req_layer;
                  state_reg <= ST_CALC;
               end
            end
            ST_CALC: begin
               addr_reg      <= group_start(cfg_sel, k_reg);
               remaining_reg <= cfg_sel.words;
               if (!layer_ok || cfg_sel.words == '0) begin
                  finish_reg <= 1'b1;
                  state_reg  <= ST_DONE;
               end else begin
                  state_reg <= ST_STREAM;
               end
            end
            ST_STREAM: begin
               if (rd_issue) begin
                  addr_reg      <= addr_reg + WT_AW'(1);
                  remaining_reg <= remaining_reg - CNT_W'(1);
                  if (remaining_reg == CNT_W'(1)) begin
                     state_reg <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               if (drain_empty) begin
                  finish_reg <= 1'b1;
                  state_reg  <= ST_DONE;
               end
            end
            ST_DONE: begin
               // Held while the controller keeps its request up.
               if (!req_valid) begin
                  finish_reg <= 1'b0;
                  state_reg  <= ST_IDLE;
               end
            end
            default: begin
               finish_reg <= 1'b0;
               state_reg  <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef FILTER_STREAM_PERF_EN
   logic [31:0] perf_words_reg;
   logic [31:0] perf_stall_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_words_reg <= '0;
         perf_stall_reg <= '0;
      end else begin
         if (pop && perf_words_reg != '1) begin
            perf_words_reg <= perf_words_reg + 32'd1;
         end
         if (skid_valid && !wt_ready && perf_stall_reg != '1) begin
            perf_stall_reg <= perf_stall_reg + 32'd1;
         end
      end
   end

   assign perf_words = perf_words_reg;
   assign perf_stall = perf_stall_reg;
`endif

endmodule

// File: tb/tb_filter_stream_ctrl.sv
// Randomized bench for filter_stream_ctrl against a queue-based reference model.
// Build with FILTER_STREAM_PERF_EN to also check the perf counters.
`timescale 1ns/1ps
module tb_filter_stream_ctrl;
   import filter_stream_ctrl_pkg::*;

   logic                        clk = 1'b0;
   logic                        rst;
   logic                        req_valid;
   logic [K_W-1:0]              req_k;
   logic [LAYER_W-1:0]          req_layer;
   logic [NUM_LAYERS*WT_AW-1:0] cfg_base_addr;
   logic [NUM_LAYERS*CNT_W-1:0] cfg_words;
   logic                        mem_rd_en;
   logic [WT_AW-1:0]            mem_rd_addr;
   logic [WT_DW-1:0]            mem_rd_data;
   logic                        wt_valid;
   logic [WT_DW-1:0]            wt_data;
   logic                        wt_last;
   logic                        wt_ready;
   logic                        stream_filter_finish;
`ifdef FILTER_STREAM_PERF_EN
   logic [31:0]                 perf_words;
   logic [31:0]                 perf_stall;
`endif

   always #5 clk = ~clk;

   filter_stream_ctrl dut (
      .clk                  (clk),
      .rst                  (rst),
      .req_valid            (req_valid),
      .req_k                (req_k),
      .req_layer            (req_layer),
      .cfg_base_addr        (cfg_base_addr),
      .cfg_words            (cfg_words),
      .mem_rd_en            (mem_rd_en),
      .mem_rd_addr          (mem_rd_addr),
      .mem_rd_data          (mem_rd_data),
      .wt_valid             (wt_valid),
      .wt_data              (wt_data),
      .wt_last              (wt_last),
      .wt_ready             (wt_ready),
`ifdef FILTER_STREAM_PERF_EN
      .perf_words           (perf_words),
      .perf_stall           (perf_stall),
`endif
      .stream_filter_finish (stream_filter_finish)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int tx_id = 0;

   logic [WT_DW-1:0] mem_model [1<<WT_AW];

   // SRAM model: one-cycle read latency, garbage when not reading.
   always @(posedge clk) begin
      mem_rd_data <= mem_rd_en ? mem_model[mem_rd_addr] : WT_DW'($urandom);
      cyc <= cyc + 1;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Observation state filled by the monitor.
   logic [WT_AW-1:0] rd_q   [$];
   logic [WT_DW:0]   beat_q [$];
   int               issued, beats, first_rd_cyc, last_beat_cyc, fin_cyc;
   int               perf_beats, perf_stalls;
   logic             prev_stall, hs;
   logic [WT_DW-1:0] prev_data;
   logic             prev_last;

   always @(negedge clk) begin
      if (rst) begin
         prev_stall  = 1'b0;
         perf_beats  = 0;
         perf_stalls = 0;
      end else begin
         hs = wt_valid && wt_ready;
         if (prev_stall) begin
            chk("stall_valid", 64'(wt_valid), 64'(1));
            chk("stall_data", 64'(wt_data), 64'(prev_data));
            chk("stall_last", 64'(wt_last), 64'(prev_last));
         end
         if (mem_rd_en) begin
            chk("outstanding", 64'((issued - beats - int'(hs)) <= 1), 64'(1));
            if (rd_q.size() == 0) first_rd_cyc = cyc;
            rd_q.push_back(mem_rd_addr);
            issued++;
         end
         if (hs) begin
            beat_q.push_back({wt_last, wt_data});
            beats++;
            perf_beats++;
            last_beat_cyc = cyc;
         end
         if (wt_valid && !wt_ready) perf_stalls++;
         if (stream_filter_finish && fin_cyc < 0) fin_cyc = cyc;
         prev_stall = wt_valid && !wt_ready;
         prev_data  = wt_data;
         prev_last  = wt_last;
      end
   end

   // 0: always ready, 1: alternating, 2: low for 10 cycles, 3: random
   function automatic logic ready_val(input int mode, input int rel);
      case (mode)
         0:       return 1'b1;
         1:       return (rel % 2) == 0;
         2:       return !(rel >= 5 && rel < 15);
         default: return 1'($urandom_range(0, 1));
      endcase
   endfunction

   task automatic set_cfg(input int layer, input int base, input int words);
      cfg_base_addr[layer*WT_AW +: WT_AW] = WT_AW'(base);
      cfg_words[layer*CNT_W +: CNT_W]     = CNT_W'(words);
   endtask

   task automatic clear_obs();
      rd_q.delete();
      beat_q.delete();
      issued = 0; beats = 0;
      first_rd_cyc = -1; last_beat_cyc = -1; fin_cyc = -1;
   endtask

   task automatic run_req(input int layer, input int k, input int rmode, input int hold, input bit pulse);
      int n, base, start, req_cyc, rel, a;
      logic [WT_DW:0] e;
      n     = (layer < NUM_LAYERS) ? int'(cfg_words[layer*CNT_W +: CNT_W]) : 0;
      base  = (layer < NUM_LAYERS) ? int'(cfg_base_addr[layer*WT_AW +: WT_AW]) : 0;
      start = (base + k * n) % (1 << WT_AW);
      @(posedge clk); #1;
      clear_obs();
      req_valid = 1'b1;
      req_k     = K_W'(k);
      req_layer = LAYER_W'(layer);
      req_cyc   = cyc;
      rel       = 0;
      wt_ready  = ready_val(rmode, 0);
      while (fin_cyc < 0 && rel < 400) begin
         @(posedge clk); #1;
         rel = cyc - req_cyc;
         if (pulse) req_valid = 1'b0;
         wt_ready = ready_val(rmode, rel);
      end
      chk("fin_seen", 64'(fin_cyc >= 0), 64'(1));
      if (pulse) begin
         @(negedge clk); #1;
         chk("fin_pulse", 64'(stream_filter_finish), 64'(0));
      end else begin
         for (int h = 0; h < hold; h++) begin
            @(negedge clk); #1;
            chk("fin_hold", 64'(stream_filter_finish), 64'(1));
            @(posedge clk); #1;
         end
         req_valid = 1'b0;
         @(negedge clk); #1;
         chk("fin_last", 64'(stream_filter_finish), 64'(1));
         @(posedge clk); #1;
         @(negedge clk); #1;
         chk("fin_clear", 64'(stream_filter_finish), 64'(0));
      end
      chk("n_reads", 64'(rd_q.size()), 64'(n));
      chk("n_beats", 64'(beat_q.size()), 64'(n));
      for (int i = 0; i < n && i < rd_q.size(); i++) begin
         chk("rd_addr", 64'(rd_q[i]), 64'((start + i) % (1 << WT_AW)));
      end
      for (int i = 0; i < n && i < beat_q.size(); i++) begin
         a = (start + i) % (1 << WT_AW);
         e = {(i == n - 1), mem_model[a]};
         chk("beat", 64'(beat_q[i]), 64'(e));
      end
      if (n > 0) chk("fin_after_last", 64'(fin_cyc - last_beat_cyc), 64'(1));
      else       chk("fin_empty", 64'(fin_cyc - req_cyc), 64'(2));
      if (rmode == 0 && n > 0) begin
         chk("first_rd_lat", 64'(first_rd_cyc - req_cyc), 64'(2));
         chk("last_beat_lat", 64'(last_beat_cyc - req_cyc), 64'(n + 3));
      end
      $display("tx %0d layer=%0d k=%0d words=%0d start=%03h mode=%0d pulse=%0d beats=%0d fin=+%0d",
               tx_id, layer, k, n, start, rmode, pulse, beats, fin_cyc - req_cyc);
      tx_id++;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      int rc;
      for (int a = 0; a < (1 << WT_AW); a++) mem_model[a] = WT_DW'($urandom);
      rst = 1'b1; req_valid = 1'b0; req_k = '0; req_layer = '0; wt_ready = 1'b0;
      cfg_base_addr = '0; cfg_words = '0;
      clear_obs();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_rd_en", 64'(mem_rd_en), 64'(0));
      chk("rst_rd_addr", 64'(mem_rd_addr), 64'(0));
      chk("rst_wt_valid", 64'(wt_valid), 64'(0));
      chk("rst_wt_data", 64'(wt_data), 64'(0));
      chk("rst_wt_last", 64'(wt_last), 64'(0));
      chk("rst_finish", 64'(stream_filter_finish), 64'(0));
      @(posedge clk); #1;
      rst = 1'b0;

      set_cfg(0, 'h100, 3);
      set_cfg(1, 'h200, 5);
      set_cfg(2, 'h300, 0);
      set_cfg(3, 'h400, 8);
      run_req(0, 0, 0, 2, 1'b0);
      run_req(1, 2, 0, 0, 1'b0);
      run_req(2, 7, 0, 1, 1'b0);
      run_req(2, 0, 0, 0, 1'b1);
      run_req(3, 1, 1, 0, 1'b0);
      run_req(3, 5, 2, 0, 1'b1);
      set_cfg(0, 'hFFE, 4);
      run_req(0, 0, 0, 0, 1'b0);

      // Abort a 6-word group with reset on its second beat.
      set_cfg(1, 'h050, 6);
      @(posedge clk); #1;
      clear_obs();
      req_valid = 1'b1; req_k = K_W'(3); req_layer = LAYER_W'(1); wt_ready = 1'b1;
      rc = cyc;
      while (cyc < rc + 5) begin
         @(posedge clk); #1;
      end
      @(negedge clk); #1;
      chk("beats_at_rst", 64'(beats), 64'(2));
      rst = 1'b1; req_valid = 1'b0;
      @(posedge clk); #1;
      chk("abort_rd_en", 64'(mem_rd_en), 64'(0));
      chk("abort_rd_addr", 64'(mem_rd_addr), 64'(0));
      chk("abort_wt_valid", 64'(wt_valid), 64'(0));
      chk("abort_wt_data", 64'(wt_data), 64'(0));
      chk("abort_wt_last", 64'(wt_last), 64'(0));
      chk("abort_finish", 64'(stream_filter_finish), 64'(0));
`ifdef FILTER_STREAM_PERF_EN
      chk("abort_perf_words", 64'(perf_words), 64'(0));
      chk("abort_perf_stall", 64'(perf_stall), 64'(0));
`endif
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (3) begin
         @(negedge clk); #1;
         chk("abort_no_finish", 64'(stream_filter_finish), 64'(0));
      end
      run_req(1, 3, 0, 1, 1'b0);

      for (int t = 0; t < 24; t++) begin
         int layer;
         layer = int'($urandom_range(0, NUM_LAYERS - 1));
         set_cfg(layer, int'($urandom_range(0, (1 << WT_AW) - 1)), int'($urandom_range(0, 12)));
         run_req(layer, int'($urandom_range(0, MAX_K - 1)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end

`ifdef FILTER_STREAM_PERF_EN
      @(posedge clk); #1;
      chk("perf_words", 64'(perf_words), 64'(perf_beats));
      chk("perf_stall", 64'(perf_stall), 64'(perf_stalls));
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
